// File: rtl/muladd_frame_accum.sv
// ---------------------------------------------------------------------------
// muladd_frame_accum
//
// Purpose:
//   Downstream stage of the fused mul-add pipeline (y = a*b + c). It takes the
//   signed y stream one beat per accepted cycle and sums cfg_len beats into
//   one frame result, like a dot product. The saturated frame sum is then
//   offered on a valid/ready output port. in_ready goes back to the upstream
//   controller, which uses it to gate the pipeline enable.
//
// Ports:
//   clock      in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   cfg_len    in   LEN_W  beats per frame, sampled on the first beat (0 -> 1)
//   in_data    in   IN_W   signed mul-add result
//   in_valid   in   1      in_data valid this cycle
//   in_ready   out  1      block accepts a beat this cycle
//   out_data   out  OUT_W  signed saturated frame sum
//   out_sat    out  1      result clamped, or accumulator clamped in frame
//   out_valid  out  1      out_data/out_sat valid
//   out_ready  in   1      consumer takes the result
// ---------------------------------------------------------------------------
module muladd_frame_accum #(
    parameter int IN_W  = 16,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int LEN_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [LEN_W-1:0]        cfg_len,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic {
        ACCUM,
        HOLD
    } state_t;

    // Accumulator limits, held one bit wider so the raw sum can be compared
    // against them without overflowing.
    localparam logic signed [ACC_W:0] ACC_MAX_W = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] ACC_MIN_W = {2'b11, {(ACC_W-1){1'b0}}};

    // Output limits, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] OUT_MAX_A =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN_A =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]          cnt_q, cnt_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic                      ovf_q, ovf_d;
    logic signed [OUT_W-1:0]   out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;

    logic signed [ACC_W:0]     in_ext;
    logic signed [ACC_W:0]     sum_wide;
    logic signed [ACC_W-1:0]   acc_next;
    logic                      acc_clamp;
    logic signed [OUT_W-1:0]   out_next;
    logic                      out_clamp;
    logic [LEN_W-1:0]          eff_len;
    logic                      beat_last;

    // State and datapath registers; reset returns to an empty frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // Saturating add, output clamp, frame-end detection and next state.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;

        in_ext   = {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
        sum_wide = {acc_q[ACC_W-1], acc_q} + in_ext;

        acc_clamp = 1'b0;
        acc_next  = sum_wide[ACC_W-1:0];
        if (sum_wide > ACC_MAX_W) begin
            acc_next  = ACC_MAX_W[ACC_W-1:0];
            acc_clamp = 1'b1;
        end else if (sum_wide < ACC_MIN_W) begin
            acc_next  = ACC_MIN_W[ACC_W-1:0];
            acc_clamp = 1'b1;
        end

        out_clamp = 1'b0;
        out_next  = acc_next[OUT_W-1:0];
        if (acc_next > OUT_MAX_A) begin
            out_next  = OUT_MAX_A[OUT_W-1:0];
            out_clamp = 1'b1;
        end else if (acc_next < OUT_MIN_A) begin
            out_next  = OUT_MIN_A[OUT_W-1:0];
            out_clamp = 1'b1;
        end

        // The first beat of a frame uses the live cfg_len; later beats use
        // the copy latched on that first beat.
        if (cnt_q == '0) begin
            eff_len = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        end else begin
            eff_len = len_q;
        end
        beat_last = (cnt_q == eff_len - LEN_W'(1));

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    if (cnt_q == '0) begin
                        len_d = eff_len;
                    end
                    if (beat_last) begin
                        out_data_d = out_next;
                        out_sat_d  = ovf_q | acc_clamp | out_clamp;
                        state_d    = HOLD;
                        acc_d      = '0;
                        cnt_d      = '0;
                        ovf_d      = 1'b0;
                    end else begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + LEN_W'(1);
                        ovf_d = ovf_q | acc_clamp;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule
